// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns one register command at a time into an AXI4-Lite
// write or read, and returns the slave's response on a valid/ready channel.
module axil_cmd_master #(
  parameter int ADDR_W    = 21,
  parameter int STALL_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              stall,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  input  logic [1:0]        m_axil_bresp,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W offered, each drops on its own handshake
  // WR_RESP | bready high, waiting for the write response
  // RD_REQ  | AR offered
  // RD_RESP | rready high, waiting for read data
  // RSP     | response held on rsp_* until rsp_ready
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  localparam int CNT_W = $clog2(STALL_CYC + 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              stall_q, stall_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    stall_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cnt_d       = CNT_W'(STALL_CYC);
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = awvalid_q & ~m_axil_awready;
        wvalid_d  = wvalid_q & ~m_axil_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axil_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // stall timer counts down from STALL_CYC; terminal count of zero means stalled
    busy_q = (state_q == WR_REQ) || (state_q == WR_RESP) ||
             (state_q == RD_REQ) || (state_q == RD_RESP);
    busy_d = (state_d == WR_REQ) || (state_d == WR_RESP) ||
             (state_d == RD_REQ) || (state_d == RD_RESP);
    if (busy_d) begin
      if (busy_q && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      stall_d = (cnt_d == '0);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign stall          = stall_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a delay-configurable AXI4-Lite slave
// model plus hand-computed cycle expectations.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [20:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, stall;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [20:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [31:0] r_data_cfg = '0;
  logic [1:0]  r_resp_cfg = '0, b_resp_cfg = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  int b_hs = 0, ar_hi = 0;
  int n_chk = 0, n_fail = 0;
  int k;

  axil_cmd_master #(.ADDR_W(21), .STALL_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .stall(stall),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
    .m_axil_awprot(awprot), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_bvalid(bvalid),
    .m_axil_bready(bready), .m_axil_bresp(bresp), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata),
    .m_axil_rresp(rresp)
  );

  always #5 clk = ~clk;

  // handshake bookkeeping, sampled with pre-edge values
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    end else begin
      if (arvalid) ar_hi++;
      if (bvalid && bready) begin b_pend = 1'b0; b_hs++; end
      if (rvalid && rready) r_pend = 1'b0;
      if (arvalid && arready) r_pend = 1'b1;
      if (awvalid && awready) aw_got = 1'b1;
      if (wvalid && wready) w_got = 1'b1;
      if (aw_got && w_got) begin b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
    end
  end

  // slave drives its side on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (b_pend) begin bvalid = (b_cnt >= b_dly); bresp = b_resp_cfg; b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      if (r_pend) begin
        rvalid = (r_cnt >= r_dly); rdata = r_data_cfg; rresp = r_resp_cfg; r_cnt++;
      end else begin rvalid = 1'b0; r_cnt = 0; end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [20:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!rsp_valid && cyc < 40);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #12;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_awvalid", 32'(awvalid), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_awaddr", 32'(awaddr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // read, delayed AR and R, SLVERR, then 5 cycles of response backpressure
    ar_dly = 3; r_dly = 2; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b10;
    ar_hi = 0;
    send_cmd(1'b0, 21'h00_0044, 32'h0, 4'h0);
    check_val("arvalid_n1", 32'(arvalid), 32'd1);
    check_val("araddr", 32'(araddr), 32'h44);
    check_val("arprot", 32'(arprot), 32'd0);
    wait_rsp(k);
    check_val("rd_latency", 32'(k), 32'd7);
    check_val("arvalid_cycles", 32'(ar_hi), 32'd4);
    check_val("rd_rdata", rsp_rdata, 32'h1234_5678);
    check_val("rd_resp", 32'(rsp_resp), 32'd2);
    check_val("rd_write", 32'(rsp_write), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_valid", 32'(rsp_valid), 32'd1);
      check_val("bp_rdata", rsp_rdata, 32'h1234_5678);
      check_val("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    take_rsp();
    check_val("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);

    // zero-wait write
    ar_dly = 0; r_dly = 0; b_resp_cfg = 2'b00; b_hs = 0;
    send_cmd(1'b1, 21'h00_0010, 32'hDEAD_BEEF, 4'hF);
    check_val("wr_awvalid", 32'(awvalid), 32'd1);
    check_val("wr_wvalid", 32'(wvalid), 32'd1);
    check_val("wr_awaddr", 32'(awaddr), 32'h10);
    check_val("wr_wdata", wdata, 32'hDEAD_BEEF);
    check_val("wr_wstrb", 32'(wstrb), 32'hF);
    check_val("wr_awprot", 32'(awprot), 32'd0);
    @(posedge clk); #1;
    check_val("wr_bready_n2", 32'(bready), 32'd1);
    check_val("wr_awvalid_n2", 32'(awvalid), 32'd0);
    wait_rsp(k);
    check_val("wr_latency", 32'(k), 32'd1);
    check_val("wr_write", 32'(rsp_write), 32'd1);
    check_val("wr_resp", 32'(rsp_resp), 32'd0);
    check_val("wr_rdata", rsp_rdata, 32'd0);
    check_val("wr_bready_off", 32'(bready), 32'd0);
    check_val("wr_b_count", 32'(b_hs), 32'd1);
    take_rsp();

    // split write: W accepted two cycles before AW
    aw_dly = 2; w_dly = 0; b_resp_cfg = 2'b01; b_hs = 0;
    send_cmd(1'b1, 21'h1F_FFFC, 32'hCAFE_0001, 4'h3);
    check_val("sp_wvalid_n1", 32'(wvalid), 32'd1);
    @(posedge clk); #1;
    check_val("sp_wvalid_n2", 32'(wvalid), 32'd0);
    check_val("sp_awvalid_n2", 32'(awvalid), 32'd1);
    check_val("sp_bready_n2", 32'(bready), 32'd0);
    @(posedge clk); #1;
    check_val("sp_awvalid_n3", 32'(awvalid), 32'd1);
    @(posedge clk); #1;
    check_val("sp_awvalid_n4", 32'(awvalid), 32'd0);
    check_val("sp_bready_n4", 32'(bready), 32'd1);
    wait_rsp(k);
    check_val("sp_latency", 32'(k), 32'd1);
    check_val("sp_resp", 32'(rsp_resp), 32'd1);
    check_val("sp_b_count", 32'(b_hs), 32'd1);
    take_rsp();

    // stall: AW withheld for 12 cycles, STALL_CYC = 8
    aw_dly = 12; b_resp_cfg = 2'b00;
    send_cmd(1'b1, 21'h00_0100, 32'h0000_00AA, 4'h1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      check_val("st_awvalid", 32'(awvalid), 32'd1);
      check_val("st_stall", 32'(stall), (i >= 8) ? 32'd1 : 32'd0);
    end
    wait_rsp(k);
    check_val("st_latency", 32'(k), 32'd2);
    check_val("st_stall_cleared", 32'(stall), 32'd0);
    take_rsp();

    // reset while in RD_RESP, then a fresh read
    aw_dly = 0; ar_dly = 0; r_dly = 10;
    send_cmd(1'b0, 21'h00_0020, 32'h0, 4'h0);
    @(posedge clk); #1;
    check_val("rr_rready", 32'(rready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rr_arvalid", 32'(arvalid), 32'd0);
    check_val("rr_rready_rst", 32'(rready), 32'd0);
    check_val("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rr_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    r_dly = 0; r_data_cfg = 32'hA5A5_0F0F; r_resp_cfg = 2'b00;
    send_cmd(1'b0, 21'h00_0024, 32'h0, 4'h0);
    wait_rsp(k);
    check_val("rr2_latency", 32'(k), 32'd2);
    check_val("rr2_rdata", rsp_rdata, 32'hA5A5_0F0F);
    check_val("rr2_resp", 32'(rsp_resp), 32'd0);
    take_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
